instruction_fetch: RTL

Fetch stage directly downstream of `program_counter` in the multicycle CPU.
- On a start request it samples `pc`, runs a request/ready read on the instruction memory port and latches the returned word into an instruction register for decode.
- It drives `pc_write`/`next_pc` back to `program_counter` so the PC advances by 4 once per completed fetch.
- Misaligned addresses, and optionally stalled memory, are trapped in a fault state.

---
 rtl/instruction_fetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: samples pc, reads instruction memory, holds the word for decode.
// Optional memory-stall timeout fault enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic        instr_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        pc_write,
    output logic [31:0] next_pc,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StFault} state_e;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseTimeout  = 2'b10;
    localparam logic [7:0] TimeoutLimit  = 8'(TIMEOUT_CYCLES);

    state_e state;
    logic   pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout_hit;

    // Fires on the REQ cycle that would bring the stall count up to the limit.
    assign timeout_hit = ((wait_cnt + 8'd1) == TimeoutLimit);
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutLimit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            mem_addr    <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            pc_write    <= 1'b0;
            next_pc     <= 32'h0;
            fault_cause <= CauseNone;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= 8'd0;
`endif
        end else begin
            pc_write <= 1'b0;
            if (flush) begin
                state       <= StIdle;
                instr_valid <= 1'b0;
                fault_cause <= CauseNone;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt    <= 8'd0;
`endif
            end else begin
                unique case (state)
                    StIdle, StHold: begin
                        // HOLD only accepts a new fetch once decode has taken the current one.
                        if (state == StIdle || instr_ack) begin
                            instr_valid <= 1'b0;
                            state       <= StIdle;
                            if (fetch_start && pc_aligned) begin
                                mem_addr <= pc;
                                state    <= StReq;
`ifdef FETCH_TIMEOUT_EN
                                wait_cnt <= 8'd0;
`endif
                            end else if (fetch_start) begin
                                instr_pc    <= pc;
                                next_pc     <= pc + 32'd4;
                                fault_cause <= CauseMisalign;
                                state       <= StFault;
                            end
                        end
                    end
                    StReq: begin
                        if (mem_ready) begin
                            instr       <= mem_rdata;
                            instr_pc    <= mem_addr;
                            next_pc     <= mem_addr + 32'd4;
                            instr_valid <= 1'b1;
                            pc_write    <= 1'b1;
                            state       <= StHold;
                        end
`ifdef FETCH_TIMEOUT_EN
                        else if (timeout_hit) begin
                            fault_cause <= CauseTimeout;
                            state       <= StFault;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
`endif
                    end
                    StFault: begin
                        state <= StFault;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign mem_req = (state == StReq);
    assign busy    = (state != StIdle);
    assign fault   = (state == StFault);

endmodule
